// File: rtl/th_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// th_cmd_sequencer : replays a table of wide harness commands as OWIDTH chunks
// Revision 1.0
// ============================================================================
module th_cmd_sequencer #(
  parameter int CMD_WIDTH = 104,
  parameter int OWIDTH    = 8,
  parameter int NUM_CMDS  = 8,
  parameter bit REVERSE   = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cfg_write,
  input  logic [$clog2(NUM_CMDS)-1:0] i_cfg_addr,
  input  logic [CMD_WIDTH-1:0]        i_cfg_data,
  input  logic [$clog2(NUM_CMDS):0]   i_cfg_num_cmds,
  input  logic [CNT_WIDTH-1:0]        i_cfg_loops,
  input  logic                        i_start,
  input  logic                        i_abort,
  output logic [OWIDTH-1:0]           o_out_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  input  logic [OWIDTH-1:0]           i_resp_in,
  input  logic                        i_resp_in_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CNT_WIDTH-1:0]        o_cmd_count,
  output logic [CNT_WIDTH-1:0]        o_loop_count,
  output logic [CNT_WIDTH-1:0]        o_resp_count
);

  localparam int c_CHUNKS = CMD_WIDTH / OWIDTH;
  localparam int c_AW     = $clog2(NUM_CMDS);
  localparam int c_NW     = c_AW + 1;
  localparam int c_JW     = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;

  localparam logic [c_JW-1:0]      c_LAST_CHUNK = c_JW'(c_CHUNKS - 1);
  localparam logic [c_NW-1:0]      c_MAX_CMDS   = c_NW'(NUM_CMDS);
  localparam logic [c_NW-1:0]      c_NUM_ONE    = c_NW'(1);
  localparam logic [c_AW-1:0]      c_ADDR_ONE   = c_AW'(1);
  localparam logic [c_JW-1:0]      c_CHUNK_ONE  = c_JW'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CMD_WIDTH-1:0]   r_table [NUM_CMDS];
  logic [CMD_WIDTH-1:0]   r_shift;
  logic [c_JW-1:0]        r_chunk;
  logic [c_AW-1:0]        r_entry;
  logic [c_NW-1:0]        r_num;
  logic [CNT_WIDTH-1:0]   r_loops;
  logic [CNT_WIDTH-1:0]   r_cmd_cnt;
  logic [CNT_WIDTH-1:0]   r_loop_cnt;
  logic [CNT_WIDTH-1:0]   r_resp_cnt;
  logic                   r_resp_en;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_xfer;
  logic                   w_last_chunk;
  logic                   w_last_entry;
  logic                   w_run_done;
  logic [c_AW-1:0]        w_next_entry;
  logic [CNT_WIDTH-1:0]   w_loop_next;
  logic [c_NW-1:0]        w_start_num;
  logic [OWIDTH-1:0]      w_chunk_out;
  logic [CMD_WIDTH-1:0]   w_shift_nxt;
  logic                   w_resp_data_unused;

  assign w_xfer       = r_valid & i_out_ready;
  assign w_last_chunk = (r_chunk == c_LAST_CHUNK);
  assign w_last_entry = ({1'b0, r_entry} == (r_num - c_NUM_ONE));
  assign w_next_entry = w_last_entry ? '0 : (r_entry + c_ADDR_ONE);
  assign w_loop_next  = r_loop_cnt + c_CNT_ONE;
  assign w_run_done   = w_last_entry && (r_loops != '0) && (w_loop_next == r_loops);
  assign w_start_num  = (i_cfg_num_cmds > c_MAX_CMDS) ? c_MAX_CMDS : i_cfg_num_cmds;

  // Only the response beat matters; its payload is deliberately dropped.
  assign w_resp_data_unused = ^i_resp_in;

  // The held record is shifted so the outgoing chunk is always at a fixed slice.
  generate
    if (REVERSE) begin : g_msb_first
      assign w_chunk_out = r_shift[CMD_WIDTH-1 -: OWIDTH];
      assign w_shift_nxt = {r_shift[CMD_WIDTH-OWIDTH-1:0], {OWIDTH{1'b0}}};
    end else begin : g_lsb_first
      assign w_chunk_out = r_shift[OWIDTH-1:0];
      assign w_shift_nxt = {{OWIDTH{1'b0}}, r_shift[CMD_WIDTH-1:OWIDTH]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CMDS; i++) begin
        r_table[i] <= '0;
      end
    end else if (i_cfg_write && (r_state != S_SHIFT)) begin
      r_table[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_chunk    <= '0;
      r_entry    <= '0;
      r_num      <= '0;
      r_loops    <= '0;
      r_cmd_cnt  <= '0;
      r_loop_cnt <= '0;
      r_resp_cnt <= '0;
      r_resp_en  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (i_resp_in_valid && r_resp_en) begin
        r_resp_cnt <= r_resp_cnt + c_CNT_ONE;
      end

      if (i_abort) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              r_cmd_cnt  <= '0;
              r_loop_cnt <= '0;
              r_resp_cnt <= '0;
              r_resp_en  <= 1'b1;
              r_chunk    <= '0;
              r_entry    <= '0;
              r_num      <= w_start_num;
              r_loops    <= i_cfg_loops;
              r_shift    <= r_table[0];
              if (w_start_num != '0) begin
                r_state <= S_SHIFT;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end else begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end

          S_SHIFT: begin
            if (w_xfer) begin
              if (w_last_chunk) begin
                // Next record loads on the same edge so chunk 0 follows with no bubble.
                r_chunk   <= '0;
                r_cmd_cnt <= r_cmd_cnt + c_CNT_ONE;
                r_entry   <= w_next_entry;
                r_shift   <= r_table[w_next_entry];
                if (w_last_entry) begin
                  r_loop_cnt <= w_loop_next;
                  if (w_run_done) begin
                    r_state <= S_DONE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end
              end else begin
                r_chunk <= r_chunk + c_CHUNK_ONE;
                r_shift <= w_shift_nxt;
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_out_data   = w_chunk_out;
  assign o_out_valid  = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cmd_count  = r_cmd_cnt;
  assign o_loop_count = r_loop_cnt;
  assign o_resp_count = r_resp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_th_cmd_sequencer.sv
`default_nettype none
// tb_th_cmd_sequencer : randomized bench checking both chunk orders against a
// beat-stream model built directly from the table contents.
module tb_th_cmd_sequencer;

  localparam int CW   = 104;
  localparam int OW   = 8;
  localparam int NC   = 8;
  localparam int CNTW = 32;
  localparam int K    = CW / OW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_cfg_write = 1'b0;
  logic [2:0]      i_cfg_addr = '0;
  logic [CW-1:0]   i_cfg_data = '0;
  logic [3:0]      i_cfg_num_cmds = '0;
  logic [CNTW-1:0] i_cfg_loops = '0;
  logic            i_start = 1'b0;
  logic            i_abort = 1'b0;
  logic            i_out_ready = 1'b0;
  logic [OW-1:0]   i_resp_in = '0;
  logic            i_resp_in_valid = 1'b0;

  logic [OW-1:0]   a_data, b_data;
  logic            a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [CNTW-1:0] a_cmd, a_loop, a_resp, b_cmd, b_loop, b_resp;

  always #5 clk = ~clk;

  th_cmd_sequencer #(.CMD_WIDTH(CW), .OWIDTH(OW), .NUM_CMDS(NC), .REVERSE(1'b1), .CNT_WIDTH(CNTW)) u_msb (
    .clk(clk), .rst(rst), .i_cfg_write(i_cfg_write), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .i_cfg_num_cmds(i_cfg_num_cmds), .i_cfg_loops(i_cfg_loops),
    .i_start(i_start), .i_abort(i_abort), .o_out_data(a_data), .o_out_valid(a_valid),
    .i_out_ready(i_out_ready), .i_resp_in(i_resp_in), .i_resp_in_valid(i_resp_in_valid),
    .o_busy(a_busy), .o_done(a_done), .o_cmd_count(a_cmd), .o_loop_count(a_loop),
    .o_resp_count(a_resp)
  );

  th_cmd_sequencer #(.CMD_WIDTH(CW), .OWIDTH(OW), .NUM_CMDS(NC), .REVERSE(1'b0), .CNT_WIDTH(CNTW)) u_lsb (
    .clk(clk), .rst(rst), .i_cfg_write(i_cfg_write), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .i_cfg_num_cmds(i_cfg_num_cmds), .i_cfg_loops(i_cfg_loops),
    .i_start(i_start), .i_abort(i_abort), .o_out_data(b_data), .o_out_valid(b_valid),
    .i_out_ready(i_out_ready), .i_resp_in(i_resp_in), .i_resp_in_valid(i_resp_in_valid),
    .o_busy(b_busy), .o_done(b_done), .o_cmd_count(b_cmd), .o_loop_count(b_loop),
    .o_resp_count(b_resp)
  );

  int            n_total = 0;
  int            n_pass  = 0;
  logic [CW-1:0] model_tab [NC];
  logic [OW-1:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int            beats, bubbles, run_cyc, resp_exp;
  bit            stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_rec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[CW-1:0];
  endfunction

  // Chunk j of a record, by plain shifting of the whole word.
  function automatic logic [OW-1:0] chunk(input logic [CW-1:0] rec, input int j, input bit msb_first);
    int            sh;
    logic [CW-1:0] s;
    sh = msb_first ? (K - 1 - j) * OW : j * OW;
    s  = rec >> sh;
    return s[OW-1:0];
  endfunction

  task automatic build(input int n, input int loops);
    exp_a.delete();
    exp_b.delete();
    for (int l = 0; l < loops; l++)
      for (int e = 0; e < n; e++)
        for (int j = 0; j < K; j++) begin
          exp_a.push_back(chunk(model_tab[e], j, 1'b1));
          exp_b.push_back(chunk(model_tab[e], j, 1'b0));
        end
  endtask

  task automatic write_entry(input int e, input logic [CW-1:0] d);
    i_cfg_write = 1'b1;
    i_cfg_addr  = 3'(e);
    i_cfg_data  = d;
    tick();
    i_cfg_write = 1'b0;
    model_tab[e] = d;
  endtask

  task automatic start_run(input int n, input int loops);
    i_cfg_num_cmds = 4'(n);
    i_cfg_loops    = CNTW'(loops);
    i_start        = 1'b1;
    tick();
    i_start        = 1'b0;
  endtask

  // rmode 0: ready always high. rmode 1: random ready with a forced 1,0,0,1
  // burst, plus stray Start, CfgWrite and response beats during the run.
  task automatic stream(input int rmode, input int abort_at, input int budget);
    int            pat = 0;
    bit            stalled = 1'b0;
    logic [OW-1:0] held_a = '0;
    logic [OW-1:0] held_b = '0;
    beats = 0; bubbles = 0; run_cyc = 0;
    got_a.delete(); got_b.delete();
    while (!a_done && run_cyc < budget) begin
      if (abort_at > 0 && beats == abort_at) begin
        i_out_ready = 1'b0;
        i_abort     = 1'b1;
        tick();
        i_abort     = 1'b0;
        return;
      end
      if (rmode == 0) i_out_ready = 1'b1;
      else if (beats >= 6 && pat < 4) begin
        i_out_ready = stall_pat[pat];
        pat++;
      end else i_out_ready = ($urandom_range(0, 1) == 1);
      if (rmode == 1) begin
        i_start         = ($urandom_range(0, 9) == 0);
        i_resp_in_valid = ($urandom_range(0, 2) == 0);
        i_resp_in       = 8'($urandom);
        if (i_resp_in_valid) resp_exp++;
        i_cfg_write     = (run_cyc == 3);
        i_cfg_addr      = '0;
        i_cfg_data      = ~model_tab[0];
      end
      if (stalled && a_valid) begin
        check("stall_hold_msb", CW'(a_data), CW'(held_a));
        check("stall_hold_lsb", CW'(b_data), CW'(held_b));
      end
      if (!a_valid) bubbles++;
      else if (i_out_ready) begin
        got_a.push_back(a_data);
        got_b.push_back(b_data);
        if (beats < exp_a.size()) begin
          check("beat_msb", CW'(a_data), CW'(exp_a[beats]));
          check("beat_lsb", CW'(b_data), CW'(exp_b[beats]));
        end else check("beat_overrun", CW'(beats), CW'(exp_a.size()));
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_a  = a_data;
        held_b  = b_data;
      end
      tick();
      run_cyc++;
    end
    i_start = 1'b0;
    i_resp_in_valid = 1'b0;
    i_cfg_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            n, loops;
    logic [CW-1:0] orig0;

    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", CW'(a_valid), CW'(0));
    check("rst_busy",  CW'(a_busy),  CW'(0));
    check("rst_done",  CW'(a_done),  CW'(0));
    check("rst_data",  CW'(a_data),  CW'(0));
    check("rst_cmd",   CW'(a_cmd),   CW'(0));
    check("rst_loop",  CW'(a_loop),  CW'(0));
    check("rst_resp",  CW'(a_resp),  CW'(0));

    i_resp_in_valid = 1'b1;
    repeat (3) tick();
    i_resp_in_valid = 1'b0;
    check("idle_resp_ignored", CW'(a_resp), CW'(0));

    for (int e = 0; e < NC; e++) write_entry(e, rand_rec());

    // Three commands, one pass, ready held high.
    start_run(3, 1);
    check("start_latency", CW'(a_valid), CW'(1));
    check("start_busy",    CW'(a_busy),  CW'(1));
    build(3, 1);
    stream(0, 0, 200);
    check("t1_beats",    CW'(beats),   CW'(39));
    check("t1_cycles",   CW'(run_cyc), CW'(39));
    check("t1_bubbles",  CW'(bubbles), CW'(0));
    check("t1_first_msb", CW'(got_a[0]),  CW'(model_tab[0][103:96]));
    check("t1_beat13_msb", CW'(got_a[13]), CW'(model_tab[1][103:96]));
    check("t1_first_lsb", CW'(got_b[0]),  CW'(model_tab[0][7:0]));
    check("t1_beat12_lsb", CW'(got_b[12]), CW'(model_tab[0][103:96]));
    check("t1_cmd",   CW'(a_cmd),   CW'(3));
    check("t1_loop",  CW'(a_loop),  CW'(1));
    check("t1_done",  CW'(a_done),  CW'(1));
    check("t1_valid", CW'(a_valid), CW'(0));
    check("t1_busy",  CW'(a_busy),  CW'(0));

    // Random table size and loop count with backpressure and stray inputs.
    n     = $urandom_range(2, 8);
    loops = $urandom_range(1, 3);
    orig0 = model_tab[0];
    resp_exp = 0;
    start_run(n, loops);
    build(n, loops);
    stream(1, 0, 5000);
    check("t2_done",  CW'(a_done),  CW'(1));
    check("t2_beats", CW'(beats),   CW'(K * n * loops));
    check("t2_cmd",   CW'(a_cmd),   CW'(n * loops));
    check("t2_loop",  CW'(a_loop),  CW'(loops));
    check("t2_resp",  CW'(a_resp),  CW'(resp_exp));
    check("t2_cmd_lsb", CW'(b_cmd), CW'(n * loops));

    // Empty table goes straight to DONE; late responses still counted.
    start_run(0, 1);
    check("t3_done",  CW'(a_done),  CW'(1));
    check("t3_valid", CW'(a_valid), CW'(0));
    check("t3_cmd",   CW'(a_cmd),   CW'(0));
    check("t3_loop",  CW'(a_loop),  CW'(0));
    i_resp_in_valid = 1'b1;
    repeat (7) tick();
    i_resp_in_valid = 1'b0;
    check("t3_resp7",      CW'(a_resp),  CW'(7));
    check("t3_valid_late", CW'(a_valid), CW'(0));
    start_run(1, 1);
    check("t3_resp_clear", CW'(a_resp), CW'(0));
    build(1, 1);
    stream(0, 0, 100);
    check("t3_beats",       CW'(beats),    CW'(K));
    check("t3_entry0_kept", CW'(got_a[0]), CW'(orig0[103:96]));

    // Endless loops, aborted five chunks into command 21.
    start_run(2, 0);
    build(2, 11);
    stream(0, 10 * 2 * K + 5, 2000);
    check("t4_beats", CW'(beats),   CW'(10 * 2 * K + 5));
    check("t4_valid", CW'(a_valid), CW'(0));
    check("t4_busy",  CW'(a_busy),  CW'(0));
    check("t4_done",  CW'(a_done),  CW'(0));
    check("t4_cmd",   CW'(a_cmd),   CW'(20));
    check("t4_loop",  CW'(a_loop),  CW'(10));
    tick();
    check("t4_idle_valid", CW'(a_valid), CW'(0));

    // Asynchronous reset in the middle of a command.
    start_run(3, 1);
    i_out_ready = 1'b1;
    repeat (3) tick();
    check("t5_pre_busy", CW'(a_busy), CW'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_valid",    CW'(a_valid), CW'(0));
    check("t5_busy",     CW'(a_busy),  CW'(0));
    check("t5_data_msb", CW'(a_data),  CW'(0));
    check("t5_data_lsb", CW'(b_data),  CW'(0));
    check("t5_cmd",      CW'(a_cmd),   CW'(0));
    check("t5_resp",     CW'(a_resp),  CW'(0));
    tick();
    rst = 1'b0;
    for (int e = 0; e < NC; e++) model_tab[e] = '0;
    tick();
    start_run(1, 1);
    build(1, 1);
    stream(0, 0, 100);
    check("t6_beats", CW'(beats), CW'(K));
    check("t6_cmd",   CW'(a_cmd), CW'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/th_cmd_sequencer.md
Name: th_cmd_sequencer

Overview:
Programmable on-chip command stimulus source for the test harness. It holds a table of up to NumCmds wide test-harness commands (opcode/address/data/count records). On Start it serializes each command into OWidth-bit UART-sized chunks with a valid/ready handshake, replays the table a configurable number of times, and counts returned response chunks. It sits in front of the UART transmit path and generalises the fixed, hard-wired command sequence used for bring-up.

Parameters:
CmdWidth, 104, bits per command record; must be a multiple of OWidth.
OWidth, 8, output chunk width (UART width).
NumCmds, 8, command table depth; power of two, at least 2.
Reverse, 1, 1 = most-significant chunk first; 0 = least-significant chunk first.
CntWidth, 32, width of the loop, command and response counters.

Ports:
Clock  in  1  single clock for the whole block.
Reset  in  1  asynchronous reset, active-high.
CfgWrite  in  1  writes CfgData into table entry CfgAddr.
CfgAddr  in  log2(NumCmds)  table write index.
CfgData  in  CmdWidth  command record.
CfgNumCmds  in  log2(NumCmds)+1  number of active entries, 0..NumCmds; sampled on Start.
CfgLoops  in  CntWidth  number of table passes; 0 = run until Abort; sampled on Start.
Start  in  1  begin the sequence (accepted in IDLE or DONE only).
Abort  in  1  stop immediately.
OutData  out  OWidth  current chunk.
OutValid  out  1  chunk valid.
OutReady  in  1  downstream accepts the chunk.
RespIn  in  OWidth  response chunk (data is ignored; only the beat is counted).
RespInValid  in  1  response beat.
Busy  out  1  high in SHIFT.
Done  out  1  high in DONE.
CmdCount  out  CntWidth  commands fully sent since Start.
LoopCount  out  CntWidth  table passes completed since Start.
RespCount  out  CntWidth  response beats seen since Start.

Behaviour:
- Reset values:
  - State IDLE.
  - OutValid, Busy and Done are 0.
  - OutData, CmdCount, LoopCount and RespCount are 0.
  - Table contents are 0.
- Chunks per command: K = CmdWidth/OWidth. Chunk index j runs 0..K-1.
  - Reverse=1: chunk j = bits [CmdWidth-1-j*OWidth -: OWidth].
  - Reverse=0: chunk j = bits [j*OWidth +: OWidth].
- States:
  - IDLE:
    - Start with CfgNumCmds>0 → SHIFT. The configuration is latched, the entry-0 record is loaded, and all counters are cleared.
    - Start with CfgNumCmds=0 → DONE, counters cleared.
  - SHIFT:
    - OutValid=1. OutData = chunk j of the held record.
    - Transfer = OutValid & OutReady. On each transfer, j advances.
    - Transfer of chunk K-1:
      - CmdCount increments.
      - The next entry is loaded in the same cycle, so the next command's chunk 0 is presented the following cycle with no bubble.
    - On the last entry of a pass: LoopCount increments and the entry index wraps to 0.
    - When LoopCount reaches the latched loop count (non-zero loops) → DONE, and OutValid drops the next cycle.
  - DONE: Done=1 and all counters hold. Start re-runs from IDLE semantics, with counters cleared in the same cycle.
- Latency: Start at edge t gives OutValid=1 after edge t. Holding OutReady=1 yields exactly K × N × L consecutive transfers, where N = active entries and L = loops.
- OutData is stable while OutValid=1 and OutReady=0.
- Abort has priority over all other inputs in any state:
  - next state IDLE, OutValid=0;
  - the partial command is discarded and CmdCount does not increment;
  - counters hold their values for inspection.
- CfgWrite:
  - Honoured in IDLE and DONE.
  - Ignored while Busy, so the table is immutable during a run.
- Start while Busy: ignored.
- RespInValid:
  - Increments RespCount in every state except IDLE after reset.
  - Responses that arrive after DONE are still counted.
  - RespCount is cleared only by Start.
- Counters wrap modulo 2^CntWidth. No saturation.
- Start and Abort in the same cycle: Abort wins, and the state is IDLE.

Test Plan:
- Table = {A, B, C}, CmdWidth=104, OWidth=8, Reverse=1, CfgNumCmds=3, CfgLoops=1, OutReady=1 → 39 consecutive beats. The first beat is A[103:96]; beat 13 is B[103:96]. Then CmdCount=3, LoopCount=1, Done=1.
- Same table with Reverse=0 → first beat is A[7:0]; beat 12 is A[103:96].
- OutReady toggling 1,0,0,1 during the middle of a command → OutData is held stable while stalled, no beat is dropped or duplicated, and the total beat count is still 39.
- CfgLoops=0, CfgNumCmds=2 → runs past 10 passes (LoopCount=10). Abort after the 5th chunk of a command → OutValid=0 the next cycle, CmdCount=20, state IDLE.
- CfgNumCmds=0 with Start → Done=1 the next cycle, OutValid never asserted.
- CfgWrite to entry 0 while Busy → no change, and the next run emits the original record.
- 7 RespInValid pulses → RespCount=7; Start clears it to 0.
- Reset asserted during SHIFT → all outputs are 0 immediately (asynchronous).
